sobel_grad: RTL and testbench

SOBEL_GRAD -- requirements
Module: sobel_grad

---
 rtl/sobel_pkg.sv | 55 +++++
 rtl/sobel_abs_grad.sv | 65 ++++++
 rtl/sobel_grad.sv | 115 +++++++++++
 tb/tb_sobel_grad.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, types and arithmetic helpers for the Sobel gradient pipeline.
package sobel_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned WIN_W = 72;
  localparam int unsigned IMG_W = 640;
  localparam int unsigned IMG_H = 480;

  // Byte-lane index of each window pixel; lane n occupies win[n*8+7:n*8].
  localparam int unsigned LANE_P00 = 8;
  localparam int unsigned LANE_P10 = 7;
  localparam int unsigned LANE_P20 = 6;
  localparam int unsigned LANE_P01 = 5;
  localparam int unsigned LANE_P11 = 4;
  localparam int unsigned LANE_P21 = 3;
  localparam int unsigned LANE_P02 = 2;
  localparam int unsigned LANE_P12 = 1;
  localparam int unsigned LANE_P22 = 0;

  // Weighted 1-2-1 sums, signed gradients, gradient magnitudes, total magnitude.
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned GRAD_W = 11;
  localparam int unsigned ABS_W  = 10;
  localparam int unsigned MAG_W  = 11;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [ABS_W-1:0] abs_t;
  typedef logic [MAG_W-1:0] mag_t;

  // Left/right column sums and top/bottom row sums of one window.
  typedef struct packed {
    sum_t l;
    sum_t r;
    sum_t t;
    sum_t b;
  } dir_sums_t;

  function automatic pix_t win_pix(input logic [WIN_W-1:0] win, input int unsigned lane);
    return win[lane*PIX_W +: PIX_W];
  endfunction

  // a + 2*b + c, never exceeds 1020.
  function automatic sum_t tri_sum(input pix_t a, input pix_t b, input pix_t c);
    return sum_t'(a) + sum_t'({b, 1'b0}) + sum_t'(c);
  endfunction

  // |a - b| through an 11-bit signed difference.
  function automatic abs_t abs_diff(input sum_t a, input sum_t b);
    logic signed [GRAD_W-1:0] g;
    g = $signed({1'b0, a}) - $signed({1'b0, b});
    return g[GRAD_W-1] ? abs_t'(-g) : abs_t'(g);
  endfunction

endpackage

// File: rtl/sobel_abs_grad.sv
// Pipeline stages S1 (directional sums) and S2 (absolute gradients), held when en is low.
module sobel_abs_grad
  import sobel_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIN_W-1:0] win_in,
  output logic             out_valid,
  output logic [ABS_W-1:0] abs_gx,
  output logic [ABS_W-1:0] abs_gy
);

  logic      s1_valid_q, s1_valid_d;
  dir_sums_t s1_sums_q, s1_sums_d;
  logic      s2_valid_q, s2_valid_d;
  abs_t      abs_gx_q, abs_gx_d;
  abs_t      abs_gy_q, abs_gy_d;

  // Next-state for S1 and S2; both hold their contents while disabled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sums_d  = s1_sums_q;
    s2_valid_d = s2_valid_q;
    abs_gx_d   = abs_gx_q;
    abs_gy_d   = abs_gy_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s1_sums_d.l = tri_sum(win_pix(win_in, LANE_P00), win_pix(win_in, LANE_P10),
                            win_pix(win_in, LANE_P20));
      s1_sums_d.r = tri_sum(win_pix(win_in, LANE_P02), win_pix(win_in, LANE_P12),
                            win_pix(win_in, LANE_P22));
      s1_sums_d.t = tri_sum(win_pix(win_in, LANE_P00), win_pix(win_in, LANE_P01),
                            win_pix(win_in, LANE_P02));
      s1_sums_d.b = tri_sum(win_pix(win_in, LANE_P20), win_pix(win_in, LANE_P21),
                            win_pix(win_in, LANE_P22));
      s2_valid_d  = s1_valid_q;
      abs_gx_d    = abs_diff(s1_sums_q.r, s1_sums_q.l);
      abs_gy_d    = abs_diff(s1_sums_q.b, s1_sums_q.t);
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sums_q  <= '0;
      s2_valid_q <= 1'b0;
      abs_gx_q   <= '0;
      abs_gy_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sums_q  <= s1_sums_d;
      s2_valid_q <= s2_valid_d;
      abs_gx_q   <= abs_gx_d;
      abs_gy_q   <= abs_gy_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign abs_gx    = abs_gx_q;
  assign abs_gy    = abs_gy_q;

endmodule

// File: rtl/sobel_grad.sv
// Sobel edge magnitude: 3-stage stallable pipeline with line/frame position flags.
module sobel_grad
  import sobel_pkg::*;
#(
  parameter int unsigned OUT_W  = IMG_W - 2,
  parameter int unsigned OUT_H  = IMG_H - 2,
  parameter int unsigned THRESH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIN_W-1:0] win_in,
  input  logic             win_valid,
  output logic             win_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_eol,
  output logic             pix_eof
);

  localparam int unsigned COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned LINE_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_W - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(OUT_H - 1);

  logic              stall;
  logic              adv;
  logic              xfer;
  logic              s2_valid;
  abs_t              abs_gx;
  abs_t              abs_gy;
  mag_t              mag;
  pix_t              pix_next;
  logic              pix_valid_q, pix_valid_d;
  pix_t              pix_out_q, pix_out_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              col_last;
  logic              line_last;

  // Handshake: a held output pixel freezes every stage at once.
  always_comb begin
    stall = pix_valid_q && !pix_ready;
    adv   = !stall;
    xfer  = pix_valid_q && pix_ready;
  end

  sobel_abs_grad u_abs_grad (
    .clk      (clk),
    .reset    (reset),
    .en       (adv),
    .in_valid (win_valid),
    .win_in   (win_in),
    .out_valid(s2_valid),
    .abs_gx   (abs_gx),
    .abs_gy   (abs_gy)
  );

  // S3 datapath: magnitude, then saturation or binarisation.
  always_comb begin
    mag = mag_t'(abs_gx) + mag_t'(abs_gy);
    if (THRESH == 0) begin
      pix_next = (mag > mag_t'(255)) ? '1 : pix_t'(mag);
    end else begin
      pix_next = (32'(mag) >= THRESH) ? '1 : '0;
    end
  end

  // S3 next-state and position counters; counters move only on a pixel transfer.
  always_comb begin
    pix_valid_d = pix_valid_q;
    pix_out_d   = pix_out_q;
    col_d       = col_q;
    line_d      = line_q;
    if (adv) begin
      pix_valid_d = s2_valid;
      pix_out_d   = pix_next;
    end
    if (xfer) begin
      if (col_last) begin
        col_d  = '0;
        line_d = line_last ? '0 : line_q + LINE_W'(1);
      end else begin
        col_d  = col_q + COL_W'(1);
      end
    end
  end

  // S3 and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid_q <= 1'b0;
      pix_out_q   <= '0;
      col_q       <= '0;
      line_q      <= '0;
    end else begin
      pix_valid_q <= pix_valid_d;
      pix_out_q   <= pix_out_d;
      col_q       <= col_d;
      line_q      <= line_d;
    end
  end

  // Flags come from the counters, which are frozen while the output is held.
  always_comb begin
    col_last  = (col_q == COL_LAST);
    line_last = (line_q == LINE_LAST);
    win_ready = adv;
    pix_out   = pix_out_q;
    pix_valid = pix_valid_q;
    pix_eol   = pix_valid_q && col_last;
    pix_eof   = pix_valid_q && col_last && line_last;
  end

endmodule

// File: tb/tb_sobel_grad.sv
// Directed bench: full-size saturating instance and a small thresholded instance share stimulus.
module tb_sobel_grad;

  localparam int AW = 638;
  localparam int AH = 478;
  localparam int BW = 6;
  localparam int BH = 4;
  localparam int NV = 14;

  typedef struct {
    logic [71:0] win;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [71:0] win_in;
  logic        win_valid;
  logic        pix_ready;
  logic        win_ready_a, win_ready_b;
  logic [7:0]  pix_out_a, pix_out_b;
  logic        pix_valid_a, pix_valid_b;
  logic        pix_eol_a, pix_eol_b;
  logic        pix_eof_a, pix_eof_b;

  vec_t tbl [NV];
  int   n_chk;
  int   n_pass;
  int   fa;
  int   fb;

  sobel_grad #(.OUT_W(AW), .OUT_H(AH), .THRESH(0)) u_dut_a (
    .clk(clk), .reset(reset), .win_in(win_in), .win_valid(win_valid),
    .win_ready(win_ready_a), .pix_out(pix_out_a), .pix_valid(pix_valid_a),
    .pix_ready(pix_ready), .pix_eol(pix_eol_a), .pix_eof(pix_eof_a)
  );

  sobel_grad #(.OUT_W(BW), .OUT_H(BH), .THRESH(100)) u_dut_b (
    .clk(clk), .reset(reset), .win_in(win_in), .win_valid(win_valid),
    .win_ready(win_ready_b), .pix_out(pix_out_b), .pix_valid(pix_valid_b),
    .pix_ready(pix_ready), .pix_eol(pix_eol_b), .pix_eof(pix_eof_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [71:0] mk(input logic [7:0] p00, p10, p20, p01, p11, p21,
                                     p02, p12, p22);
    return {p00, p10, p20, p01, p11, p21, p02, p12, p22};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive windows tbl[i % NV] and check n output pixels on both instances.
  task automatic stream(input int n, input bit flood, input bit rnd, input int stall_len,
                        input int limit);
    int   wi, ra, rb, cyc, stall_left;
    bit   seen, acc, prev_stall;
    logic [7:0] prev_out_a;
    logic prev_eol_a;
    wi = 0; ra = 0; rb = 0; cyc = 0; stall_left = 0;
    seen = 0; prev_stall = 0; prev_out_a = '0; prev_eol_a = 0;
    while (ra < n) begin
      if (cyc >= limit) begin
        chk("stream_timeout", ra, n);
        break;
      end
      win_valid = flood || (wi < n);
      win_in    = tbl[wi % NV].win;
      if (!seen && pix_valid_a) begin
        seen = 1;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        pix_ready = 1'b0;
        stall_left--;
      end else begin
        pix_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      if (prev_stall) begin
        chk("hold_valid", pix_valid_a, 1);
        chk("hold_out", pix_out_a, prev_out_a);
        chk("hold_eol", pix_eol_a, prev_eol_a);
      end
      chk("win_ready_a", win_ready_a, !(pix_valid_a && !pix_ready));
      chk("win_ready_b", win_ready_b, !(pix_valid_a && !pix_ready));
      if (!pix_valid_a) chk("flags_idle_a", {pix_eol_a, pix_eof_a}, 0);
      if (pix_valid_a && pix_ready) begin
        chk("out_a", pix_out_a, tbl[ra % NV].exp_a);
        chk("eol_a", pix_eol_a, (fa % AW) == AW - 1);
        chk("eof_a", pix_eof_a, (fa % (AW * AH)) == AW * AH - 1);
        ra++; fa++;
      end
      if (pix_valid_b && pix_ready) begin
        chk("out_b", pix_out_b, tbl[rb % NV].exp_b);
        chk("eol_b", pix_eol_b, (fb % BW) == BW - 1);
        chk("eof_b", pix_eof_b, (fb % (BW * BH)) == BW * BH - 1);
        rb++; fb++;
      end
      prev_stall = pix_valid_a && !pix_ready;
      prev_out_a = pix_out_a;
      prev_eol_a = pix_eol_a;
      acc = win_valid && win_ready_a;
      @(posedge clk); #1;
      if (acc) wi++;
      cyc++;
    end
    chk("count_b", rb, ra);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    win_valid = 1'b0;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    fa = 0;
    fb = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; fa = 0; fb = 0;
    tbl[0]  = '{mk(8'h80,8'h80,8'h80,8'h80,8'h80,8'h80,8'h80,8'h80,8'h80), 8'h00, 8'h00};
    tbl[1]  = '{mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h10,8'h10,8'h10), 8'h40, 8'h00};
    tbl[2]  = '{mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hFF,8'hFF,8'hFF), 8'hFF, 8'hFF};
    tbl[3]  = '{mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h20,8'h20,8'h20), 8'h80, 8'hFF};
    tbl[4]  = '{mk(8'h10,8'h10,8'h10,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 8'h40, 8'h00};
    tbl[5]  = '{mk(8'h00,8'h00,8'h20,8'h00,8'h00,8'h20,8'h00,8'h00,8'h20), 8'h80, 8'hFF};
    tbl[6]  = '{mk(8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 8'hFF, 8'hFF};
    tbl[7]  = '{mk(8'h00,8'h00,8'h00,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00), 8'h00, 8'h00};
    tbl[8]  = '{mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h32,8'h00,8'h00), 8'h64, 8'hFF};
    tbl[9]  = '{mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h31,8'h00,8'h00), 8'h62, 8'h00};
    tbl[10] = '{mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h80,8'h00,8'h00), 8'hFF, 8'hFF};
    tbl[11] = '{mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h7F,8'h00,8'h00), 8'hFE, 8'hFF};
    tbl[12] = '{mk(8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF), 8'h00, 8'h00};
    tbl[13] = '{mk(8'hFF,8'h00,8'h00,8'hFF,8'h00,8'h00,8'hFF,8'h00,8'h00), 8'hFF, 8'hFF};

    reset = 1'b1; win_valid = 1'b0; win_in = '0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_a", pix_valid_a, 0);
    chk("rst_out_a", pix_out_a, 0);
    chk("rst_flags_a", {pix_eol_a, pix_eof_a}, 0);
    chk("rst_ready_a", win_ready_a, 1);
    chk("rst_valid_b", pix_valid_b, 0);

    // Isolated windows: latency, saturation, threshold boundaries, gradient signs.
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      win_in = tbl[i].win;
      win_valid = 1'b1;
      #1;
      chk("tbl_ready", win_ready_a, 1);
      @(posedge clk); #1;
      win_valid = 1'b0;
      chk("tbl_lat1", pix_valid_a, 0);
      @(posedge clk); #1;
      chk("tbl_lat2", pix_valid_a, 0);
      @(posedge clk); #1;
      chk("tbl_lat3", pix_valid_a, 1);
      chk("tbl_valid_b", pix_valid_b, 1);
      chk($sformatf("tbl_out_a[%0d]", i), pix_out_a, tbl[i].exp_a);
      chk($sformatf("tbl_out_b[%0d]", i), pix_out_b, tbl[i].exp_b);
      chk("tbl_eol_a", pix_eol_a, 0);
    end
    @(posedge clk); #1;
    chk("tbl_drained", pix_valid_a, 0);

    // Four windows with the output held for five cycles.
    do_reset();
    stream(4, 0, 0, 5, 100);
    win_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_dup", pix_valid_a, 0);
    end

    // Two small frames plus a few pixels under random back-pressure.
    do_reset();
    stream(2 * BW * BH + 7, 0, 1, 0, 2000);
    win_valid = 1'b0;

    // Reset with the pipeline full after 100 pixels.
    do_reset();
    stream(100, 1, 0, 0, 500);
    chk("pre_rst_valid", pix_valid_a, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid_a", pix_valid_a, 0);
    chk("mid_rst_out_a", pix_out_a, 0);
    chk("mid_rst_flags_a", {pix_eol_a, pix_eof_a}, 0);
    chk("mid_rst_ready_a", win_ready_a, 1);
    chk("mid_rst_valid_b", pix_valid_b, 0);
    win_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    fa = 0;
    fb = 0;
    stream(AW + 62, 0, 1, 0, 5000);
    win_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
